// File: rtl/pc_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_select_unit
// Brief    : PC register with fixed-priority next-PC select, circular return
//            address stack, stall hold and misaligned-target trap.
// Revision : 1.0
// ============================================================================
module pc_select_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
   parameter int               INSTR_BYTES  = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             exc_req,
   input  logic             jr_valid,
   input  logic [WIDTH-1:0] jr_addr,
   input  logic             ret,
   input  logic             j_valid,
   input  logic [WIDTH-1:0] j_addr,
   input  logic             link,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_addr,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic [2:0]       src,
   output logic             misalign_err,
   output logic             ras_underflow,
   output logic             ras_empty,
   output logic             ras_full
);

   localparam int               c_ptr_w      = $clog2(RAS_DEPTH);
   localparam int               c_cnt_w      = c_ptr_w + 1;
   localparam logic [WIDTH-1:0] c_step       = WIDTH'(INSTR_BYTES);
   localparam logic [WIDTH-1:0] c_align_mask = WIDTH'(INSTR_BYTES - 1);
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(RAS_DEPTH);

   localparam logic [2:0] c_src_seq  = 3'd0;
   localparam logic [2:0] c_src_br   = 3'd1;
   localparam logic [2:0] c_src_j    = 3'd2;
   localparam logic [2:0] c_src_ret  = 3'd3;
   localparam logic [2:0] c_src_jr   = 3'd4;
   localparam logic [2:0] c_src_exc  = 3'd5;
   localparam logic [2:0] c_src_mis  = 3'd6;
   localparam logic [2:0] c_src_hold = 3'd7;

   logic [WIDTH-1:0]   pc_q, pc_d;
   logic [2:0]         src_q, src_d;
   logic               mis_q, mis_d;
   logic               uf_q, uf_d;
   logic [c_ptr_w-1:0] top_q, top_d;
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   ras_q [RAS_DEPTH];

   logic [WIDTH-1:0]   w_pc_plus;
   logic               w_push;
   logic               w_pop;
   logic               w_align_chk;

   assign w_pc_plus = pc_q + c_step;

   always_comb begin
      pc_d        = w_pc_plus;
      src_d       = c_src_seq;
      mis_d       = 1'b0;
      uf_d        = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_align_chk = 1'b0;

      if (exc_req) begin
         pc_d  = EXC_VECTOR;
         src_d = c_src_exc;
      end else if (stall) begin
         pc_d  = pc_q;
         src_d = c_src_hold;
      end else if (jr_valid) begin
         pc_d        = jr_addr;
         src_d       = c_src_jr;
         w_align_chk = 1'b1;
      end else if (ret) begin
         // An empty-stack return falls through as a sequential step.
         if (cnt_q != '0) begin
            pc_d  = ras_q[top_q];
            src_d = c_src_ret;
            w_pop = 1'b1;
         end else begin
            uf_d = 1'b1;
         end
      end else if (j_valid) begin
         pc_d        = j_addr;
         src_d       = c_src_j;
         w_push      = link;
         w_align_chk = 1'b1;
      end else if (br_taken) begin
         pc_d        = br_addr;
         src_d       = c_src_br;
         w_align_chk = 1'b1;
      end

      if (w_align_chk && ((pc_d & c_align_mask) != '0)) begin
         pc_d   = EXC_VECTOR;
         src_d  = c_src_mis;
         mis_d  = 1'b1;
         w_push = 1'b0;
      end
   end

   always_comb begin
      top_d = top_q;
      cnt_d = cnt_q;
      if (w_push) begin
         // Full stack wraps onto the oldest entry; count saturates.
         top_d = top_q + 1'b1;
         if (cnt_q != c_depth) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (w_pop) begin
         top_d = top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         src_q <= c_src_seq;
         mis_q <= 1'b0;
         uf_q  <= 1'b0;
         top_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         src_q <= src_d;
         mis_q <= mis_d;
         uf_q  <= uf_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         if (w_push) begin
            ras_q[top_d] <= w_pc_plus;
         end
      end
   end

   assign pc            = pc_q;
   assign pc_plus       = w_pc_plus;
   assign src           = src_q;
   assign misalign_err  = mis_q;
   assign ras_underflow = uf_q;
   assign ras_empty     = (cnt_q == '0);
   assign ras_full      = (cnt_q == c_depth);

endmodule
`default_nettype wire

// File: tb/tb_pc_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_select_unit
// Brief    : Directed bench for pc_select_unit with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_pc_select_unit;

   localparam int          W     = 32;
   localparam int          IB    = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] EV    = 32'h0000_0080;
   localparam logic [31:0] STEP  = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, exc_req = 1'b0, jr_valid = 1'b0, ret = 1'b0;
   logic        j_valid = 1'b0, link = 1'b0, br_taken = 1'b0;
   logic [31:0] jr_addr = '0, j_addr = '0, br_addr = '0;

   logic [31:0] pc, pc_plus;
   logic [2:0]  src;
   logic        misalign_err, ras_underflow, ras_empty, ras_full;

   pc_select_unit #(
      .WIDTH       (W),
      .RESET_VECTOR(RV),
      .EXC_VECTOR  (EV),
      .INSTR_BYTES (IB),
      .RAS_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .exc_req      (exc_req),
      .jr_valid     (jr_valid),
      .jr_addr      (jr_addr),
      .ret          (ret),
      .j_valid      (j_valid),
      .j_addr       (j_addr),
      .link         (link),
      .br_taken     (br_taken),
      .br_addr      (br_addr),
      .pc           (pc),
      .pc_plus      (pc_plus),
      .src          (src),
      .misalign_err (misalign_err),
      .ras_underflow(ras_underflow),
      .ras_empty    (ras_empty),
      .ras_full     (ras_full)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   // Reference model: PC value, last source, pulse flags, stack as a queue.
   logic [31:0] m_pc  = RV;
   logic [2:0]  m_src = 3'd0;
   bit          m_mis = 1'b0;
   bit          m_uf  = 1'b0;
   logic [31:0] m_ras [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc  = RV;
      m_src = 3'd0;
      m_mis = 1'b0;
      m_uf  = 1'b0;
      m_ras.delete();
   endtask

   task automatic model_push(input logic [31:0] a);
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(a);
   endtask

   task automatic model_take(input logic [31:0] tgt, input logic [2:0] s, input bit call);
      if ((tgt % STEP) != 32'd0) begin
         m_pc  = EV;
         m_src = 3'd6;
         m_mis = 1'b1;
      end else begin
         if (call) model_push(m_pc + STEP);
         m_pc  = tgt;
         m_src = s;
      end
   endtask

   task automatic model_step();
      m_mis = 1'b0;
      m_uf  = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else if (exc_req) begin
         m_pc  = EV;
         m_src = 3'd5;
      end else if (stall) begin
         m_src = 3'd7;
      end else if (jr_valid) begin
         model_take(jr_addr, 3'd4, 1'b0);
      end else if (ret) begin
         if (m_ras.size() != 0) begin
            m_pc  = m_ras.pop_back();
            m_src = 3'd3;
         end else begin
            m_pc  = m_pc + STEP;
            m_src = 3'd0;
            m_uf  = 1'b1;
         end
      end else if (j_valid) begin
         model_take(j_addr, 3'd2, link);
      end else if (br_taken) begin
         model_take(br_addr, 3'd1, 1'b0);
      end else begin
         m_pc  = m_pc + STEP;
         m_src = 3'd0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc",            pc,                   m_pc);
         check("pc_plus",       pc_plus,              m_pc + STEP);
         check("src",           32'(src),             32'(m_src));
         check("misalign_err",  32'(misalign_err),    32'(m_mis));
         check("ras_underflow", 32'(ras_underflow),   32'(m_uf));
         check("ras_empty",     32'(ras_empty),       32'(m_ras.size() == 0));
         check("ras_full",      32'(ras_full),        32'(m_ras.size() == DEPTH));
      end
   end

   task automatic clr();
      stall = 1'b0; exc_req = 1'b0; jr_valid = 1'b0; ret = 1'b0;
      j_valid = 1'b0; link = 1'b0; br_taken = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   logic [31:0] lifo_exp [4] = '{32'h4004, 32'h3004, 32'h2004, 32'h1004};

   initial begin
      clr();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      check("rst_pc",    pc,              32'h0);
      check("rst_src",   32'(src),        32'd0);
      check("rst_empty", 32'(ras_empty),  32'd1);
      check("rst_full",  32'(ras_full),   32'd0);

      repeat (3) tick();
      check("free_pc", pc, 32'hC);

      exc_req = 1; jr_valid = 1; jr_addr = 32'h100; j_valid = 1; j_addr = 32'h200;
      br_taken = 1; br_addr = 32'h300;
      tick();
      check("prio_exc_pc",  pc,       32'h80);
      check("prio_exc_src", 32'(src), 32'd5);
      exc_req = 0;
      tick();
      check("prio_jr_pc",  pc,       32'h100);
      check("prio_jr_src", 32'(src), 32'd4);
      clr();

      stall = 1; br_taken = 1; br_addr = 32'h40;
      tick(); tick();
      check("stall_pc",  pc,       32'h100);
      check("stall_src", 32'(src), 32'd7);
      exc_req = 1;
      tick();
      check("stall_exc_pc", pc, 32'h80);
      clr();

      j_valid = 1; j_addr = 32'h10;
      tick(); clr();
      check("j_pc", pc, 32'h10);
      j_valid = 1; link = 1; j_addr = 32'h400;
      tick(); clr();
      check("call_pc",    pc,             32'h400);
      check("call_empty", 32'(ras_empty), 32'd0);
      ret = 1;
      tick();
      check("ret_pc",    pc,             32'h14);
      check("ret_empty", 32'(ras_empty), 32'd1);
      tick();
      check("uf_pc",    pc,                 32'h18);
      check("uf_pulse", 32'(ras_underflow), 32'd1);
      clr();
      tick();
      check("uf_clear", 32'(ras_underflow), 32'd0);

      for (int i = 1; i <= 5; i++) begin
         j_valid = 1; link = 1; j_addr = 32'(i) << 12;
         tick();
      end
      clr();
      check("five_full", 32'(ras_full), 32'd1);
      for (int k = 0; k < 4; k++) begin
         ret = 1;
         tick();
         check("lifo_pc", pc, lifo_exp[k]);
      end
      check("lifo_empty", 32'(ras_empty), 32'd1);
      tick();
      check("lifo_uf_pc", pc, 32'h1008);
      clr();

      br_taken = 1; br_addr = 32'h102;
      tick(); clr();
      check("mis_br_pc",  pc,                32'h80);
      check("mis_br_src", 32'(src),          32'd6);
      check("mis_pulse",  32'(misalign_err), 32'd1);
      tick();
      check("mis_clear",  32'(misalign_err), 32'd0);
      j_valid = 1; link = 1; j_addr = 32'h206;
      tick(); clr();
      check("mis_call_src",   32'(src),       32'd6);
      check("mis_call_empty", 32'(ras_empty), 32'd1);
      jr_valid = 1; jr_addr = 32'h101;
      tick(); clr();
      check("mis_jr_src", 32'(src), 32'd6);

      j_valid = 1; link = 1; j_addr = 32'h600;
      tick(); clr();
      jr_valid = 1; jr_addr = 32'h700; ret = 1;
      tick(); clr();
      check("jr_over_ret_pc",    pc,             32'h700);
      check("jr_over_ret_empty", 32'(ras_empty), 32'd0);
      stall = 1; ret = 1;
      tick();
      check("stall_ret_pc", pc, 32'h700);
      stall = 0;
      tick(); clr();
      check("late_ret_pc", pc, 32'h84);
      ret = 1; j_valid = 1; link = 1; j_addr = 32'h900;
      tick(); clr();
      check("ret_over_call_pc",    pc,                 32'h88);
      check("ret_over_call_uf",    32'(ras_underflow), 32'd1);
      check("ret_over_call_empty", 32'(ras_empty),     32'd1);

      j_valid = 1; j_addr = 32'hFFFF_FFF8;
      tick(); clr();
      tick();
      check("wrap_pc_top",   pc,      32'hFFFF_FFFC);
      check("wrap_pc_plus",  pc_plus, 32'h0);
      tick();
      check("wrap_pc_zero",  pc,      32'h0);

      j_valid = 1; link = 1; j_addr = 32'h40;
      tick(); clr();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_pc",    pc,             32'h0);
      check("midrst_src",   32'(src),       32'd0);
      check("midrst_empty", 32'(ras_empty), 32'd1);
      tick();
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_pc", pc, 32'h4);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_select_unit.md
Name: pc_select_unit

Overview:
- Parametrised program-counter stage and next-PC selector. Successor to the two-input PC mux.
- Holds the PC register and arbitrates six next-PC sources by fixed priority: exception, jump-register, return, jump, branch, sequential.
- Includes a circular return-address stack (RAS), stall hold and misaligned-target trapping.
- Sits between the control/branch logic and the instruction memory address port.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- EXC_VECTOR, 32'h00000080, PC target on exception or misaligned redirect.
- INSTR_BYTES, 4, sequential increment; must be a power of two.
- RAS_DEPTH, 4, return-address stack entries; must be a power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS; exception still taken.
- exc_req  in  1  exception redirect request.
- jr_valid  in  1  jump-register redirect.
- jr_addr  in  WIDTH  jump-register target.
- ret  in  1  return: pop RAS, target is the popped entry.
- j_valid  in  1  direct jump.
- j_addr  in  WIDTH  direct jump target.
- link  in  1  with j_valid: push pc_plus on the RAS.
- br_taken  in  1  taken branch.
- br_addr  in  WIDTH  branch target.
- pc  out  WIDTH  current PC (registered).
- pc_plus  out  WIDTH  pc + INSTR_BYTES, combinational, wraps modulo 2^WIDTH.
- src  out  3  registered source of the last PC update: 0 seq, 1 br, 2 j, 3 ret, 4 jr, 5 exc, 6 misalign, 7 hold.
- misalign_err  out  1  registered one-cycle pulse.
- ras_underflow  out  1  registered one-cycle pulse.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (asynchronous assert on rst_n low; synchronous-safe deassert):
  - pc = RESET_VECTOR, src = 0, misalign_err = 0, ras_underflow = 0.
  - RAS count = 0, top pointer = 0, so ras_empty = 1 and ras_full = 0.
- Reset mid-operation discards any pending redirect and clears the RAS.
- Latency: all inputs are sampled on the rising edge; the new pc is visible the following cycle. There is no other pipelining.
- Priority, highest first:
  - exc_req → EXC_VECTOR, src 5.
  - jr_valid → jr_addr, src 4.
  - ret → RAS top, src 3.
  - j_valid → j_addr, src 2.
  - br_taken → br_addr, src 1.
  - otherwise pc_plus, src 0.
- Stall: if stall = 1 and exc_req = 0, pc holds, src = 7, no RAS change, no pulses. exc_req overrides stall.
- Side effects: only the winning source's side effects occur.
  - The RAS push happens only if j_valid && link wins.
  - The pop happens only if ret wins.
  - A lower-priority ret or link is dropped.
- Misalignment: if the winning target is jr, j or br and any of its low log2(INSTR_BYTES) bits are nonzero:
  - pc = EXC_VECTOR, src = 6, misalign_err pulses for 1 cycle.
  - The RAS push for a misaligned j+link is suppressed.
- RAS is a circular buffer with a top pointer and a count.
  - Push: write pc_plus at top+1, advance top, count++ saturating at RAS_DEPTH.
  - Push when full: overwrite the oldest entry (wrap-around); count stays RAS_DEPTH.
  - Pop when not empty: target = entry[top], decrement top, count--.
  - Pop when empty: treated as sequential (pc = pc_plus, src 0), ras_underflow pulses 1 cycle, pointers unchanged.
- Pulses (misalign_err, ras_underflow) are high for exactly one cycle per event and low otherwise.
- pc wraps: pc = 2^WIDTH − INSTR_BYTES sequential → 0.

Test Plan:
- Reset then 3 free cycles with no requests → pc 0x0, 0x4, 0x8, 0xC; src = 0; ras_empty = 1.
- In the same cycle assert exc_req, jr_valid (0x100), j_valid (0x200) and br_taken (0x300) → next pc = 0x80, src = 5; repeat without exc_req → pc = 0x100, src = 4.
- Stall with br_taken = 1 (0x40) for 2 cycles → pc unchanged, src = 7. Then stall plus exc_req → pc = 0x80.
- At pc = 0x10, j_valid + link to 0x400, then ret → pc 0x400, then 0x14, and ras_empty returns to 1. Then ret again → pc = 0x18, ras_underflow pulses for one cycle.
- Five j+link calls with RAS_DEPTH = 4 → ras_full = 1. Four rets return the last four pushed addresses in LIFO order; the first push is lost.
- Misaligned inputs:
  - br_addr = 0x102 taken → pc = 0x80, src = 6, misalign_err high for exactly one cycle.
  - j+link to 0x206 → no push; ras_empty stays 1.
